// File: rtl/q2_i2c_target.sv
// I2C target with an NREG x 8-bit register file addressed through a pointer byte.
// Define Q2_I2C_TARGET_FILTER_EN to add a 3-sample majority glitch filter on SCL/SDA.
module q2_i2c_target #(
  parameter logic [6:0] ADDR = 7'h50,
  parameter int         NREG = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scl_in,
  input  logic              sda_in,
  output logic              sda_oe,
  output logic              wr_strobe,
  output logic [3:0]        wr_index,
  output logic [7:0]        wr_data,
  output logic [8*NREG-1:0] regs
);
  localparam int PW = $clog2(NREG);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_ADDR      = 4'd1,
    S_ADDR_ACK  = 4'd2,
    S_PTR       = 4'd3,
    S_PTR_ACK   = 4'd4,
    S_WDATA     = 4'd5,
    S_WDATA_ACK = 4'd6,
    S_RDATA     = 4'd7,
    S_RACK      = 4'd8
  } state_t;

  logic [1:0]    scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic          scl_v, sda_v;
  logic          scl_p_q, scl_p_d, sda_p_q, sda_p_d;
  logic          scl_rise_s, scl_fall_s, start_s, stop_s;
  state_t        state_q, state_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [PW-1:0] ptr_q, ptr_d, nxt_ptr_s;
  logic          sda_oe_q, sda_oe_d;
  logic          wr_strobe_q, wr_strobe_d;
  logic [3:0]    wr_index_q, wr_index_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic [7:0]    reg_q [NREG];
  logic [7:0]    reg_d [NREG];

  // Two-stage synchronizer next values
  always_comb begin
    scl_sync_d = {scl_sync_q[0], scl_in};
    sda_sync_d = {sda_sync_q[0], sda_in};
  end

  // Synchronizer flops, idle-high after reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
    end
  end

`ifdef Q2_I2C_TARGET_FILTER_EN
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic [1:0] scl_hist_q, scl_hist_d, sda_hist_q, sda_hist_d;

  // History of the two previous synchronized samples
  always_comb begin
    scl_hist_d = {scl_hist_q[0], scl_sync_q[1]};
    sda_hist_d = {sda_hist_q[0], sda_sync_q[1]};
  end

  // Filter history flops
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_hist_q <= 2'b11;
      sda_hist_q <= 2'b11;
    end else begin
      scl_hist_q <= scl_hist_d;
      sda_hist_q <= sda_hist_d;
    end
  end

  // A single-clock pulse appears once in the 3-sample window and is outvoted
  assign scl_v = maj3(scl_sync_q[1], scl_hist_q[0], scl_hist_q[1]);
  assign sda_v = maj3(sda_sync_q[1], sda_hist_q[0], sda_hist_q[1]);
`else
  assign scl_v = scl_sync_q[1];
  assign sda_v = sda_sync_q[1];
`endif

  // Edge and bus-condition detection on the cleaned bus levels
  always_comb begin
    scl_p_d    = scl_v;
    sda_p_d    = sda_v;
    scl_rise_s = scl_v & ~scl_p_q;
    scl_fall_s = ~scl_v & scl_p_q;
    start_s    = scl_v & scl_p_q & sda_p_q & ~sda_v;
    stop_s     = scl_v & scl_p_q & ~sda_p_q & sda_v;
  end

  // Protocol FSM: next state, shifter, pointer, register file and outputs
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    ptr_d       = ptr_q;
    sda_oe_d    = sda_oe_q;
    wr_strobe_d = 1'b0;
    wr_index_d  = wr_index_q;
    wr_data_d   = wr_data_q;
    reg_d       = reg_q;
    nxt_ptr_s   = ptr_q + PW'(1'b1);

    if (start_s) begin
      state_d   = S_ADDR;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
    end else if (stop_s) begin
      state_d   = S_IDLE;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d  = S_IDLE;
          sda_oe_d = 1'b0;
        end
        S_ADDR, S_PTR: begin
          if (scl_rise_s && bit_cnt_q != 4'd8) begin
            shift_d   = {shift_q[6:0], sda_v};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall_s && bit_cnt_q == 4'd8) begin
            if (state_q == S_PTR) begin
              ptr_d    = shift_q[PW-1:0];
              sda_oe_d = 1'b1;
              state_d  = S_PTR_ACK;
            end else if (shift_q[7:1] == ADDR) begin
              sda_oe_d = 1'b1;
              state_d  = S_ADDR_ACK;
            end else begin
              state_d  = S_IDLE;
            end
          end else begin
            state_d = state_q;
          end
        end
        S_ADDR_ACK: begin
          if (scl_fall_s) begin
            bit_cnt_d = 4'd0;
            if (shift_q[0]) begin
              shift_d  = reg_q[ptr_q];
              sda_oe_d = ~reg_q[ptr_q][7];
              state_d  = S_RDATA;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = S_PTR;
            end
          end else begin
            state_d = S_ADDR_ACK;
          end
        end
        S_PTR_ACK, S_WDATA_ACK: begin
          if (scl_fall_s) begin
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
            state_d   = S_WDATA;
          end else begin
            state_d = state_q;
          end
        end
        S_WDATA: begin
          if (scl_rise_s && bit_cnt_q != 4'd8) begin
            shift_d   = {shift_q[6:0], sda_v};
            bit_cnt_d = bit_cnt_q + 4'd1;
            // Commit on the rise that samples bit 0, before the ACK clock
            if (bit_cnt_q == 4'd7) begin
              wr_strobe_d   = 1'b1;
              wr_index_d    = 4'(ptr_q);
              wr_data_d     = {shift_q[6:0], sda_v};
              reg_d[ptr_q]  = {shift_q[6:0], sda_v};
              ptr_d         = nxt_ptr_s;
            end else begin
              wr_strobe_d = 1'b0;
            end
          end else if (scl_fall_s && bit_cnt_q == 4'd8) begin
            sda_oe_d = 1'b1;
            state_d  = S_WDATA_ACK;
          end else begin
            state_d = S_WDATA;
          end
        end
        S_RDATA: begin
          if (scl_rise_s) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall_s && bit_cnt_q == 4'd8) begin
            sda_oe_d = 1'b0;
            state_d  = S_RACK;
          end else if (scl_fall_s && bit_cnt_q != 4'd0) begin
            shift_d  = {shift_q[6:0], 1'b0};
            sda_oe_d = ~shift_q[6];
          end else begin
            state_d = S_RDATA;
          end
        end
        S_RACK: begin
          if (scl_rise_s) begin
            shift_d[0] = sda_v;
            bit_cnt_d  = 4'd9;
          end else if (scl_fall_s && bit_cnt_q == 4'd9) begin
            bit_cnt_d = 4'd0;
            if (!shift_q[0]) begin
              ptr_d    = nxt_ptr_s;
              shift_d  = reg_q[nxt_ptr_s];
              sda_oe_d = ~reg_q[nxt_ptr_s][7];
              state_d  = S_RDATA;
            end else begin
              state_d  = S_IDLE;
            end
          end else begin
            state_d = S_RACK;
          end
        end
        default: begin
          state_d  = S_IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_p_q     <= 1'b1;
      sda_p_q     <= 1'b1;
      state_q     <= S_IDLE;
      bit_cnt_q   <= 4'd0;
      shift_q     <= 8'h00;
      ptr_q       <= '0;
      sda_oe_q    <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_index_q  <= 4'd0;
      wr_data_q   <= 8'h00;
      reg_q       <= '{default: 8'h00};
    end else begin
      scl_p_q     <= scl_p_d;
      sda_p_q     <= sda_p_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      ptr_q       <= ptr_d;
      sda_oe_q    <= sda_oe_d;
      wr_strobe_q <= wr_strobe_d;
      wr_index_q  <= wr_index_d;
      wr_data_q   <= wr_data_d;
      reg_q       <= reg_d;
    end
  end

  for (genvar k = 0; k < NREG; k++) begin : g_regs
    assign regs[8*k +: 8] = reg_q[k];
  end

  assign sda_oe    = sda_oe_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_index  = wr_index_q;
  assign wr_data   = wr_data_q;

endmodule

// File: tb/tb_q2_i2c_target.sv
// Directed bench for q2_i2c_target: bit-banged I2C master, open-drain SDA bus model.
module tb_q2_i2c_target;
  localparam int Q = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        scl_m, sda_m;
  logic        sda_bus;
  logic        sda_oe, wr_strobe;
  logic [3:0]  wr_index;
  logic [7:0]  wr_data;
  logic [31:0] regs;

  int          checks = 0;
  int          fails  = 0;
  int          strobe_cnt = 0;
  logic [3:0]  last_idx = 4'd0;
  logic [7:0]  last_data = 8'h00;
  logic        ack;
  logic [7:0]  rd;

  always #5 clk = ~clk;

  assign sda_bus = sda_m & ~sda_oe;

  q2_i2c_target #(.ADDR(7'h50), .NREG(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .scl_in    (scl_m),
    .sda_in    (sda_bus),
    .sda_oe    (sda_oe),
    .wr_strobe (wr_strobe),
    .wr_index  (wr_index),
    .wr_data   (wr_data),
    .regs      (regs)
  );

  // Count write pulses (one count per clock the strobe is high)
  always @(negedge clk) begin
    if (wr_strobe) begin
      strobe_cnt <= strobe_cnt + 1;
      last_idx   <= wr_index;
      last_data  <= wr_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wq();
    repeat (Q) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wq();
    scl_m = 1'b1; wq();
    sda_m = 1'b0; wq();
    scl_m = 1'b0; wq();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wq();
    scl_m = 1'b1; wq();
    sda_m = 1'b1; wq();
  endtask

  task automatic write_bit(input logic b);
    sda_m = b;    wq();
    scl_m = 1'b1; wq();
    wq();
    scl_m = 1'b0; wq();
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; wq();
    scl_m = 1'b1; wq();
    b = sda_bus;  wq();
    scl_m = 1'b0; wq();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic a);
    logic bv;
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
    read_bit(bv);
    a = ~bv;
  endtask

  task automatic read_byte(output logic [7:0] b, input logic a);
    logic bv;
    b = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      read_bit(bv);
      b[i] = bv;
    end
    write_bit(~a);
  endtask

  // Same as write_byte, but a one-clock SCL pulse is inserted in the low phase of bit gbit
  task automatic write_byte_glitch(input logic [7:0] b, input int gbit, output logic a);
    logic bv;
    for (int i = 7; i >= 0; i--) begin
      if (i == gbit) begin
        sda_m = b[i]; wq();
        scl_m = 1'b1; @(posedge clk); #1;
        scl_m = 1'b0; wq();
        scl_m = 1'b1; wq();
        wq();
        scl_m = 1'b0; wq();
      end else begin
        write_bit(b[i]);
      end
    end
    read_bit(bv);
    a = ~bv;
  endtask

  initial begin
    rst = 1'b0; scl_m = 1'b1; sda_m = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("rst_sda_oe", 32'(sda_oe), 32'h0);
    chk("rst_wr_strobe", 32'(wr_strobe), 32'h0);
    chk("rst_wr_index", 32'(wr_index), 32'h0);
    chk("rst_wr_data", 32'(wr_data), 32'h0);
    chk("rst_regs", regs, 32'h0);
    rst = 1'b1; wq();

    // Single write: reg1 <= 0x5A
    i2c_start();
    write_byte(8'hA0, ack); chk("w1_ack_addr", 32'(ack), 32'h1);
    write_byte(8'h01, ack); chk("w1_ack_ptr", 32'(ack), 32'h1);
    write_byte(8'h5A, ack); chk("w1_ack_data", 32'(ack), 32'h1);
    i2c_stop();
    chk("w1_strobes", 32'(strobe_cnt), 32'd1);
    chk("w1_index", 32'(last_idx), 32'd1);
    chk("w1_data", 32'(last_data), 32'h5A);
    chk("w1_regs", regs, 32'h0000_5A00);
    chk("w1_sda_rel", 32'(sda_oe), 32'h0);

    // Pointer wrap on write: reg3 <= 0x11, reg0 <= 0x22
    i2c_start();
    write_byte(8'hA0, ack); chk("w2_ack_addr", 32'(ack), 32'h1);
    write_byte(8'h03, ack); chk("w2_ack_ptr", 32'(ack), 32'h1);
    write_byte(8'h11, ack); chk("w2_ack_d0", 32'(ack), 32'h1);
    write_byte(8'h22, ack); chk("w2_ack_d1", 32'(ack), 32'h1);
    i2c_stop();
    chk("w2_strobes", 32'(strobe_cnt), 32'd3);
    chk("w2_index", 32'(last_idx), 32'd0);
    chk("w2_data", 32'(last_data), 32'h22);
    chk("w2_regs", regs, 32'h1100_5A22);

    // reg2 <= 0xC3
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h02, ack);
    write_byte(8'hC3, ack); chk("w3_ack_data", 32'(ack), 32'h1);
    i2c_stop();
    chk("w3_regs", regs, 32'h11C3_5A22);

    // Pointer write, repeated START, read two bytes ACK/NACK
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h02, ack);
    i2c_start();
    write_byte(8'hA1, ack); chk("r1_ack_addr", 32'(ack), 32'h1);
    read_byte(rd, 1'b1);    chk("r1_byte0", 32'(rd), 32'hC3);
    read_byte(rd, 1'b0);    chk("r1_byte1", 32'(rd), 32'h11);
    chk("r1_sda_rel_nack", 32'(sda_oe), 32'h0);
    i2c_stop();
    chk("r1_no_strobe", 32'(strobe_cnt), 32'd4);

    // Read wraps from reg3 to reg0
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h03, ack);
    i2c_start();
    write_byte(8'hA1, ack);
    read_byte(rd, 1'b1);    chk("r2_byte0", 32'(rd), 32'h11);
    read_byte(rd, 1'b0);    chk("r2_wrap", 32'(rd), 32'h22);
    i2c_stop();

    // Wrong address and general call are not acknowledged
    i2c_start();
    write_byte(8'hA2, ack); chk("na_addr", 32'(ack), 32'h0);
    write_byte(8'h5A, ack); chk("na_idle", 32'(ack), 32'h0);
    i2c_stop();
    i2c_start();
    write_byte(8'h00, ack); chk("na_gcall", 32'(ack), 32'h0);
    i2c_stop();
    chk("na_regs", regs, 32'h11C3_5A22);
    chk("na_strobes", 32'(strobe_cnt), 32'd4);

    // Reset four bits into a data byte
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h01, ack);
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
    rst = 1'b0; #1;
    chk("ra_sda_oe", 32'(sda_oe), 32'h0);
    chk("ra_regs", regs, 32'h0);
    chk("ra_wr_index", 32'(wr_index), 32'h0);
    chk("ra_wr_data", 32'(wr_data), 32'h0);
    wq(); rst = 1'b1; wq();
    write_bit(1'b0); write_bit(1'b1); write_bit(1'b0); write_bit(1'b1);
    read_bit(ack);          chk("ra_no_ack", 32'(ack), 32'h1);
    i2c_stop();
    chk("ra_strobes", 32'(strobe_cnt), 32'd4);
    chk("ra_regs_after", regs, 32'h0);

    // Reset while driving a zero read bit releases SDA at once
    i2c_start();
    write_byte(8'hA1, ack); chk("rr_ack_addr", 32'(ack), 32'h1);
    for (int i = 0; i < 4; i++) read_bit(ack);
    chk("rr_driving", 32'(sda_oe), 32'h1);
    rst = 1'b0; #1;
    chk("rr_release", 32'(sda_oe), 32'h0);
    wq(); rst = 1'b1; wq();
    i2c_stop();

    // Normal operation after reset
    i2c_start();
    write_byte(8'hA0, ack); chk("p_ack_addr", 32'(ack), 32'h1);
    write_byte(8'h00, ack);
    write_byte(8'hAB, ack);
    write_byte(8'hCD, ack);
    i2c_stop();
    chk("p_regs", regs, 32'h0000_CDAB);
    chk("p_strobes", 32'(strobe_cnt), 32'd6);
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h01, ack);
    i2c_start();
    write_byte(8'hA1, ack);
    read_byte(rd, 1'b0);    chk("p_read", 32'(rd), 32'hCD);
    i2c_stop();

`ifdef Q2_I2C_TARGET_FILTER_EN
    // SCL glitch inside a data bit is filtered out
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h02, ack);
    write_byte_glitch(8'h96, 3, ack); chk("g_ack", 32'(ack), 32'h1);
    i2c_stop();
    chk("g_regs", regs, 32'h0096_CDAB);
    chk("g_strobes", 32'(strobe_cnt), 32'd7);
`endif

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/q2_i2c_target.md
Q2_I2C_TARGET -- requirements
Module: q2_i2c_target

Interface
REQ-001 SHALL have parameter ADDR, default 7'h50, the 7-bit target address.
REQ-002 SHALL have parameter NREG, default 4, the register-file depth (power of two, 2..16).
REQ-003 SHALL have ports: clk  input  1  single system clock, all state on posedge clk.
REQ-004 SHALL have ports: rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports: scl_in  input  1  bus SCL level; sda_in  input  1  bus SDA level.
REQ-006 SHALL have ports: sda_oe  output  1  1 = pull SDA low, open-drain; never drive high.
REQ-007 SHALL have ports: wr_strobe  output  1  one-clk pulse per master-written data byte; wr_index  output  4  register written; wr_data  output  8  byte written.
REQ-008 SHALL have ports: regs  output  8*NREG  flat register-file contents, reg k at bits [8k+7:8k].

Function
REQ-009 SHALL pass scl_in/sda_in through 2-FF synchronizers; all edge detection uses synchronized values.
REQ-010 SHALL detect START as SDA 1->0 while SCL=1 and STOP as SDA 0->1 while SCL=1, in any state.
REQ-011 SHALL sample SDA on each detected SCL rise; SHALL change sda_oe only on the clk after a detected SCL fall.
REQ-012 SHALL implement states IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK.
- IDLE -START-> ADDR; shift 8 bits MSB first.
- ADDR: bits[7:1]==ADDR -> ADDR_ACK (sda_oe=1 for the 9th clock); mismatch -> IDLE, sda_oe stays 0.
- ADDR_ACK: R/W=0 -> PTR; R/W=1 -> RDATA, loading reg[ptr].
- PTR: 8 bits -> ptr = byte mod NREG, ACK -> WDATA.
- WDATA: 8 bits -> reg[ptr] <= byte, wr_strobe pulse, ptr <= ptr+1 mod NREG, ACK -> WDATA.
- RDATA: drive bits MSB first (sda_oe = ~bit) -> RACK; release SDA for the 9th clock.
- RACK: master ACK (SDA=0) -> ptr+1, reload, RDATA; NACK -> IDLE.
REQ-013 SHALL treat repeated START as return to ADDR, keeping ptr.
REQ-014 SHALL on STOP go IDLE, release sda_oe same clk, keep ptr and registers.
REQ-015 SHALL wrap ptr from NREG-1 to 0 for both reads and writes.
REQ-016 SHALL assert wr_strobe 1 clk after the SCL rise sampling bit 0 of the data byte; regs update same clk.
REQ-017 SHALL never ACK a general call (address 0) unless ADDR==0.

Reset
REQ-018 SHALL on rst=0 asynchronously: state IDLE, sda_oe=0, wr_strobe=0, wr_index=0, wr_data=0, ptr=0, all regs=0, synchronizers=1.
REQ-019 SHALL abort any transfer when rst asserts mid-byte and require a new START after release.

Configuration
REQ-020 SHALL, when Q2_I2C_TARGET_FILTER_EN is defined, add a 3-sample majority filter after each synchronizer (+1 clk detection latency, rejects 1-clk glitches).
REQ-021 SHALL, without Q2_I2C_TARGET_FILTER_EN, use synchronizer outputs directly; 1-clk glitches are then visible.

Verification
REQ-022 SHALL cover: START, 0xA0, 0x01, 0x5A, STOP -> ACK x3, wr_strobe once, wr_index=1, regs[15:8]=0x5A.
REQ-023 SHALL cover: write ptr=3, data 0x11,0x22 -> reg3=0x11, reg0=0x22 (wrap), two wr_strobe pulses.
REQ-024 SHALL cover: START, 0xA0, 0x02, rSTART, 0xA1, read 2 bytes ACK/NACK -> returns reg2, reg3; SDA released after NACK.
REQ-025 SHALL cover: START, 0xA2 -> no ACK (SDA high on 9th clock), FSM IDLE, regs unchanged.
REQ-026 SHALL cover: rst=0 asserted after 4 bits of a data byte -> sda_oe=0 immediately, regs=0, no wr_strobe.
REQ-027 SHALL cover (FILTER_EN): 1-clk SCL glitch during a data bit -> no extra bit shifted, byte received correctly.
